// File: rtl/mc_open_row_trk_pkg.sv
// rtl/mc_open_row_trk_pkg.sv - shared constants, timer state encoding and helpers for the open-row tracker
package mc_open_row_trk_pkg;

    localparam int MC_NBANK  = 4;
    localparam int MC_BANK_W = 2;

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_CNT  = 2'd1,
        T_REQ  = 2'd2
    } tmr_state_t;

    // Number of set bits in a per-bank open vector (0..4 fits in 3 bits).
    function automatic logic [2:0] count_open(input logic [MC_NBANK-1:0] v);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < MC_NBANK; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/mc_idle_tmr.sv
// rtl/mc_idle_tmr.sv - idle timer that requests a precharge-all after idle_tmo access-free cycles
//
// clk, rst       : clock, asynchronous active-high reset
// any_open_next  : at least one bank open after this edge's set/clr updates
// access         : lookup or activate this cycle (restarts the idle count)
// idle_tmo       : timeout in cycles, 0 disables the timer
// pc_ack         : precharge-all for pc_req issued
// clr_all        : precharge-all / refresh issued by other means
// pc_req         : registered precharge-all request level
module mc_idle_tmr
    import mc_open_row_trk_pkg::*;
#(
    parameter int TMO_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             any_open_next,
    input  logic             access,
    input  logic [TMO_W-1:0] idle_tmo,
    input  logic             pc_ack,
    input  logic             clr_all,
    output logic             pc_req
);

    tmr_state_t       state_q;
    logic [TMO_W-1:0] cnt_q;
    logic [TMO_W-1:0] tmo_m1;
    logic             tmo_off;
    logic             req_done;

    assign tmo_m1  = idle_tmo - TMO_W'(1);
    assign tmo_off = (idle_tmo == '0);

    // The request is satisfied by any event that leaves every bank closed:
    // the acknowledge, an external clear-all, or a single precharge that
    // happened to close the last open bank.
    assign req_done = pc_ack | clr_all | ~any_open_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= T_IDLE;
            cnt_q   <= '0;
            pc_req  <= 1'b0;
        end else begin
            // pc_req follows the request state one cycle late and drops in
            // the same edge the request is retired, so it never lingers past
            // the acknowledge.
            pc_req <= (state_q == T_REQ) && !req_done;

            case (state_q)
                T_IDLE: begin
                    if (any_open_next && !tmo_off) begin
                        state_q <= T_CNT;
                        cnt_q   <= tmo_m1;
                    end
                end
                T_CNT: begin
                    if (!any_open_next || tmo_off) begin
                        state_q <= T_IDLE;
                        cnt_q   <= '0;
                    end else if (access) begin
                        cnt_q <= tmo_m1;
                    end else if (cnt_q == '0) begin
                        state_q <= T_REQ;
                    end else begin
                        cnt_q <= cnt_q - TMO_W'(1);
                    end
                end
                T_REQ: begin
                    // Accesses and a timeout change to 0 are ignored here;
                    // only closing the banks retires the request.
                    if (req_done) begin
                        state_q <= T_IDLE;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= T_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mc_open_row_trk.sv
// rtl/mc_open_row_trk.sv - SDRAM per-bank open-row tracker with page hit/miss lookup and idle precharge request
//
// clk, rst      : clock, asynchronous active-high reset
// bank_adr      : bank of the current access
// row_adr       : row of the current access
// lookup        : evaluate bank_adr/row_adr against tracked state
// bank_set      : ACTIVATE issued, mark bank_adr open with row_adr
// bank_clr      : PRECHARGE issued, mark bank_adr closed
// bank_clr_all  : precharge-all or refresh issued, close every bank
// idle_tmo      : idle timeout in cycles, 0 disables
// pc_ack        : precharge-all for pc_req issued
// lkp_vld       : one-cycle lookup result strobe
// bank_open     : looked-up bank was open (held until the next lookup)
// row_same      : looked-up bank was open on the same row (held)
// any_open      : at least one bank open
// open_cnt      : number of open banks
// pc_req        : precharge-all request level
module mc_open_row_trk
    import mc_open_row_trk_pkg::*;
#(
    parameter int ROW_W = 13,
    parameter int TMO_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [MC_BANK_W-1:0] bank_adr,
    input  logic [ROW_W-1:0]     row_adr,
    input  logic                 lookup,
    input  logic                 bank_set,
    input  logic                 bank_clr,
    input  logic                 bank_clr_all,
    input  logic [TMO_W-1:0]     idle_tmo,
    input  logic                 pc_ack,
    output logic                 lkp_vld,
    output logic                 bank_open,
    output logic                 row_same,
    output logic                 any_open,
    output logic [2:0]           open_cnt,
    output logic                 pc_req
);

    logic [MC_NBANK-1:0] open_q;
    logic [MC_NBANK-1:0] open_nxt;
    logic [ROW_W-1:0]    row_q [MC_NBANK];

    logic                close_all;
    logic                row_wr;
    logic                sel_open;
    logic                sel_hit;
    logic                access;

    // An acknowledged precharge-all closes the banks exactly like an
    // externally issued one.
    assign close_all = bank_clr_all | pc_ack;

    // Row registers only matter while the bank is open, so they are written
    // only when the activate actually leaves the bank open.
    assign row_wr = bank_set & ~bank_clr & ~close_all;

    assign access = lookup | bank_set;

    // Lookup compares against the pre-update state of this edge.
    assign sel_open = open_q[bank_adr];
    assign sel_hit  = sel_open && (row_q[bank_adr] == row_adr);

    always_comb begin
        open_nxt = open_q;
        if (close_all) begin
            open_nxt = '0;
        end else if (bank_clr) begin
            open_nxt[bank_adr] = 1'b0;
        end else if (bank_set) begin
            open_nxt[bank_adr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            open_q <= '0;
            for (int i = 0; i < MC_NBANK; i++) begin
                row_q[i] <= '0;
            end
        end else begin
            open_q <= open_nxt;
            if (row_wr) begin
                row_q[bank_adr] <= row_adr;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lkp_vld   <= 1'b0;
            bank_open <= 1'b0;
            row_same  <= 1'b0;
            any_open  <= 1'b0;
            open_cnt  <= '0;
        end else begin
            lkp_vld <= lookup;
            if (lookup) begin
                bank_open <= sel_open;
                row_same  <= sel_hit;
            end
            any_open <= |open_nxt;
            open_cnt <= count_open(open_nxt);
        end
    end

    mc_idle_tmr #(
        .TMO_W (TMO_W)
    ) u_idle_tmr (
        .clk           (clk),
        .rst           (rst),
        .any_open_next (|open_nxt),
        .access        (access),
        .idle_tmo      (idle_tmo),
        .pc_ack        (pc_ack),
        .clr_all       (bank_clr_all),
        .pc_req        (pc_req)
    );

endmodule

// File: tb/tb_mc_open_row_trk.sv
// tb/tb_mc_open_row_trk.sv - scoreboard bench for the open-row tracker
module tb_mc_open_row_trk;

    localparam int ROW_W = 13;
    localparam int TMO_W = 8;

    logic             clk;
    logic             rst;
    logic [1:0]       bank_adr;
    logic [ROW_W-1:0] row_adr;
    logic             lookup;
    logic             bank_set;
    logic             bank_clr;
    logic             bank_clr_all;
    logic [TMO_W-1:0] idle_tmo;
    logic             pc_ack;
    logic             lkp_vld;
    logic             bank_open;
    logic             row_same;
    logic             any_open;
    logic [2:0]       open_cnt;
    logic             pc_req;

    mc_open_row_trk #(
        .ROW_W (ROW_W),
        .TMO_W (TMO_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bank_adr     (bank_adr),
        .row_adr      (row_adr),
        .lookup       (lookup),
        .bank_set     (bank_set),
        .bank_clr     (bank_clr),
        .bank_clr_all (bank_clr_all),
        .idle_tmo     (idle_tmo),
        .pc_ack       (pc_ack),
        .lkp_vld      (lkp_vld),
        .bank_open    (bank_open),
        .row_same     (row_same),
        .any_open     (any_open),
        .open_cnt     (open_cnt),
        .pc_req       (pc_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: open flags and rows per bank, plus the idle rule
    // "request after idle_tmo consecutive access-free edges with a bank open".
    typedef struct {
        bit bo;
        bit rs;
    } lkp_t;

    lkp_t             sbq[$];
    bit               m_open [4];
    logic [ROW_W-1:0] m_row  [4];
    bit               m_act;
    int               m_quiet;
    bit               m_req;
    bit               exp_bo, exp_rs, exp_any, exp_pc;
    int               exp_cnt;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_open[i] = 0;
            m_row[i]  = '0;
        end
        m_act = 0; m_quiet = 0; m_req = 0;
        exp_bo = 0; exp_rs = 0; exp_any = 0; exp_pc = 0; exp_cnt = 0;
        sbq.delete();
    endtask

    task automatic model_edge();
        lkp_t e;
        int   n;
        bit   was;
        if (rst) return;
        if (lookup) begin
            e.bo = m_open[bank_adr];
            e.rs = m_open[bank_adr] && (m_row[bank_adr] == row_adr);
            sbq.push_back(e);
            exp_bo = e.bo;
            exp_rs = e.rs;
        end
        if (bank_clr_all || pc_ack) begin
            for (int i = 0; i < 4; i++) m_open[i] = 0;
        end else if (bank_clr) begin
            m_open[bank_adr] = 0;
        end else if (bank_set) begin
            m_open[bank_adr] = 1;
            m_row[bank_adr]  = row_adr;
        end
        n = 0;
        for (int i = 0; i < 4; i++) n += m_open[i];
        was = m_req;
        if (m_req) begin
            if (n == 0) m_req = 0;
        end else if (m_act) begin
            if (n == 0 || idle_tmo == 0) begin
                m_act = 0;
            end else if (lookup || bank_set) begin
                m_quiet = 0;
            end else begin
                m_quiet++;
                if (m_quiet >= int'(idle_tmo)) begin
                    m_req = 1;
                    m_act = 0;
                end
            end
        end else if (n != 0 && idle_tmo != 0) begin
            m_act   = 1;
            m_quiet = 0;
        end
        exp_pc  = was && m_req;
        exp_cnt = n;
        exp_any = (n != 0);
    endtask

    task automatic cyc(input bit l, input bit s, input bit c, input bit ca, input bit ak,
                       input logic [1:0] b, input logic [ROW_W-1:0] r);
        lookup = l; bank_set = s; bank_clr = c; bank_clr_all = ca; pc_ack = ak;
        bank_adr = b; row_adr = r;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 2'd0, '0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT strobes a result and
    // checks the status outputs against the model every cycle.
    always @(negedge clk) begin
        lkp_t e;
        if (lkp_vld) begin
            if (sbq.size() == 0) begin
                chk("lkp_vld_spurious", lkp_vld, 0);
            end else begin
                e = sbq.pop_front();
                chk("lkp_bank_open", bank_open, e.bo);
                chk("lkp_row_same", row_same, e.rs);
            end
        end else if (sbq.size() != 0) begin
            chk("lkp_vld_missing", lkp_vld, 1);
            void'(sbq.pop_front());
        end
        chk("held_bank_open", bank_open, exp_bo);
        chk("held_row_same", row_same, exp_rs);
        chk("open_cnt", open_cnt, exp_cnt);
        chk("any_open", any_open, exp_any);
        chk("pc_req", pc_req, exp_pc);
    end

    initial begin
        bit seen;
        rst = 1'b1;
        lookup = 0; bank_set = 0; bank_clr = 0; bank_clr_all = 0; pc_ack = 0;
        bank_adr = '0; row_adr = '0; idle_tmo = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_lkp_vld", lkp_vld, 0);
        chk("reset_open_cnt", open_cnt, 0);
        chk("reset_any_open", any_open, 0);
        chk("reset_pc_req", pc_req, 0);
        rst = 1'b0;

        // Activate hit / miss
        cyc(0, 1, 0, 0, 0, 2'd2, 13'h0A5);
        cyc(1, 0, 0, 0, 0, 2'd2, 13'h0A5);
        chk("t1_hit_vld", lkp_vld, 1);
        chk("t1_hit_open", bank_open, 1);
        chk("t1_hit_same", row_same, 1);
        cyc(1, 0, 0, 0, 0, 2'd2, 13'h0A6);
        chk("t1_miss_open", bank_open, 1);
        chk("t1_miss_same", row_same, 0);
        cyc(1, 0, 0, 0, 0, 2'd1, 13'h0A5);
        chk("t1_closed_open", bank_open, 0);
        chk("t1_closed_same", row_same, 0);
        idle();
        chk("t1_vld_pulse", lkp_vld, 0);

        // Same-cycle precedence
        cyc(0, 1, 1, 0, 0, 2'd3, 13'h011);
        idle();
        chk("t2_set_clr_cnt", open_cnt, 1);
        cyc(1, 1, 0, 0, 0, 2'd0, 13'h007);
        chk("t2_lkp_pre_set", bank_open, 0);
        cyc(1, 0, 0, 0, 0, 2'd0, 13'h007);
        chk("t2_lkp_post_set", bank_open, 1);
        chk("t2_lkp_post_same", row_same, 1);

        // Count and clear-all
        cyc(0, 1, 0, 0, 0, 2'd1, 13'h001);
        cyc(0, 1, 0, 0, 0, 2'd3, 13'h003);
        chk("t3_cnt4", open_cnt, 4);
        chk("t3_any", any_open, 1);
        cyc(0, 0, 0, 1, 0, 2'd0, '0);
        chk("t3_cnt0", open_cnt, 0);
        chk("t3_any0", any_open, 0);

        // Idle timeout with idle_tmo = 5
        idle_tmo = 8'd5;
        cyc(0, 1, 0, 0, 0, 2'd0, 13'h001);
        for (int k = 1; k <= 5; k++) begin
            idle();
            chk("t4_pc_req_early", pc_req, 0);
        end
        idle();
        chk("t4_pc_req_n6", pc_req, 1);
        cyc(1, 0, 0, 0, 0, 2'd0, 13'h001);
        chk("t4_access_keeps_req", pc_req, 1);
        cyc(0, 0, 0, 0, 1, 2'd0, '0);
        chk("t4_ack_drop", pc_req, 0);
        chk("t4_ack_closed", open_cnt, 0);

        // Reload keeps the timer from firing
        cyc(0, 1, 0, 0, 0, 2'd1, 13'h002);
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            repeat (3) begin
                idle();
                seen |= pc_req;
            end
            cyc(1, 0, 0, 0, 0, 2'd1, 13'h002);
            seen |= pc_req;
        end
        chk("t5_reload_no_req", seen, 0);
        cyc(0, 0, 0, 1, 0, 2'd0, '0);

        // Timer disabled
        idle_tmo = 8'd0;
        cyc(0, 1, 0, 0, 0, 2'd2, 13'h004);
        seen = 0;
        repeat (300) begin
            idle();
            seen |= pc_req;
        end
        chk("t5_disabled_no_req", seen, 0);
        cyc(0, 0, 0, 1, 0, 2'd0, '0);

        // idle_tmo = 1, then timeout change to 0 and single-bank close
        idle_tmo = 8'd1;
        cyc(0, 1, 0, 0, 0, 2'd0, 13'h005);
        idle();
        chk("tmo1_after_n1", pc_req, 0);
        idle();
        chk("tmo1_after_n2", pc_req, 1);
        idle_tmo = 8'd0;
        idle();
        chk("tmo0_keeps_req", pc_req, 1);
        cyc(0, 0, 1, 0, 0, 2'd0, '0);
        chk("last_clr_drops_req", pc_req, 0);

        // Asynchronous reset with a pending request
        idle_tmo = 8'd3;
        cyc(0, 1, 0, 0, 0, 2'd1, 13'h006);
        cyc(0, 1, 0, 0, 0, 2'd2, 13'h006);
        for (int i = 0; i < 50 && !pc_req; i++) idle();
        chk("t6_pc_req_reached", pc_req, 1);
        cyc(1, 0, 0, 0, 0, 2'd1, 13'h006);
        chk("t6_pre_cnt", open_cnt, 2);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("t6_async_pc_req", pc_req, 0);
        chk("t6_async_cnt", open_cnt, 0);
        chk("t6_async_any", any_open, 0);
        chk("t6_async_vld", lkp_vld, 0);
        chk("t6_async_open", bank_open, 0);
        idle();
        idle();
        rst = 1'b0;
        cyc(1, 0, 0, 0, 0, 2'd1, 13'h006);
        chk("t6_post_vld", lkp_vld, 1);
        chk("t6_post_open", bank_open, 0);

        // Randomized traffic against the model
        idle_tmo = 8'd2;
        for (int it = 0; it < 3000; it++) begin
            int dens;
            bit l, s, c, ca, ak;
            dens = 2 + (it / 200) % 10;
            l  = ($urandom % dens) == 0;
            s  = ($urandom % (2 * dens)) == 0;
            c  = ($urandom % 9) == 0;
            ca = ($urandom % 97) == 0;
            ak = exp_pc ? (($urandom % 4) == 0) : (($urandom % 150) == 0);
            cyc(l, s, c, ca, ak, 2'($urandom_range(0, 3)), 13'($urandom_range(0, 3)));
            if (ca || ak) idle_tmo = 8'($urandom_range(0, 6));
        end
        idle();
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
